// File: rtl/matrix_result_reader_if.sv
// Bundle of control, C-BRAM read port and result stream for matrix_result_reader.
// The master modport is the reader itself; the slave modport is the host/BRAM side.
interface matrix_result_reader_if #(
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH = 2
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  bram_en;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [ACC_WIDTH-1:0]  bram_rdata;
  logic                  m_valid;
  logic                  m_ready;
  logic [ACC_WIDTH-1:0]  m_data;
  logic                  m_last;

  modport master (
    input  start, bram_rdata, m_ready,
    output busy, done, bram_en, bram_addr, m_valid, m_data, m_last
  );

  modport slave (
    output start, bram_rdata, m_ready,
    input  busy, done, bram_en, bram_addr, m_valid, m_data, m_last
  );
endinterface

// File: rtl/matrix_result_reader.sv
// Drains result matrix C from its BRAM and streams it out through a 2-entry prefetch buffer.
// Define RESULT_TRANSPOSE_EN to issue reads column-major, delivering C^T row-major.
module matrix_result_reader #(
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned M         = 2,
  parameter int unsigned P         = 2
) (
  input logic                   clk,
  input logic                   rst,
  matrix_result_reader_if.master bus
);
  localparam int unsigned N          = M * P;
  localparam int unsigned ADDR_WIDTH = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CNT_W      = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(N - 1);
`ifdef RESULT_TRANSPOSE_EN
  localparam int unsigned RW = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned CW = (P > 1) ? $clog2(P) : 1;
`endif

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                r_state;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_bram_en;
  logic [ADDR_WIDTH-1:0] r_bram_addr;
  logic [ADDR_WIDTH-1:0] r_next_addr;
  logic [CNT_W-1:0]      r_issue_cnt;
  logic [CNT_W-1:0]      r_beat_cnt;
  logic                  r_land;
  logic [ACC_WIDTH-1:0]  r_mem [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_count;
`ifdef RESULT_TRANSPOSE_EN
  logic [RW-1:0]         r_row;
  logic [CW-1:0]         r_col;
`endif

  logic       w_pop;
  logic       w_push;
  logic       w_fifo_pop;
  logic       w_issue;
  logic [1:0] w_occ;
  logic [1:0] w_occ_next;

  // Data landing from the BRAM counts as buffered in its arrival cycle and is
  // forwarded directly when the FIFO is empty, giving first data at start+2.
  always_comb begin
    w_occ       = r_count + {1'b0, r_land};
    bus.m_valid = (w_occ != 2'd0);
    w_pop       = bus.m_valid && bus.m_ready;
    w_fifo_pop  = w_pop && (r_count != 2'd0);
    w_push      = r_land && !((r_count == 2'd0) && w_pop);
    bus.m_data  = '0;
    if (bus.m_valid)
      bus.m_data = (r_count != 2'd0) ? r_mem[r_rd_ptr] : bus.bram_rdata;
    bus.m_last  = bus.m_valid && (r_beat_cnt == LAST);
    w_occ_next  = w_occ - {1'b0, w_pop} + {1'b0, r_bram_en};
    w_issue     = ((r_state == IDLE) && bus.start) ||
                  ((r_state == READ) && (r_issue_cnt != CNT_W'(N)) && (w_occ_next < 2'd2));
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.bram_en   = r_bram_en;
  assign bus.bram_addr = r_bram_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_bram_en   <= 1'b0;
      r_bram_addr <= '0;
      r_next_addr <= '0;
      r_issue_cnt <= '0;
      r_beat_cnt  <= '0;
      r_land      <= 1'b0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_count     <= '0;
`ifdef RESULT_TRANSPOSE_EN
      r_row       <= '0;
      r_col       <= '0;
`endif
    end else begin
      r_done    <= 1'b0;
      r_bram_en <= 1'b0;
      r_land    <= r_bram_en;

      if (w_push) begin
        r_mem[r_wr_ptr] <= bus.bram_rdata;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_fifo_pop)
        r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_fifo_pop};

      if (w_pop)
        r_beat_cnt <= (r_beat_cnt == LAST) ? '0 : r_beat_cnt + CNT_W'(1);

      // Issue counters wrap to zero after the final address, ready for the next start.
      if (w_issue) begin
        r_bram_en   <= 1'b1;
        r_bram_addr <= r_next_addr;
        r_issue_cnt <= r_issue_cnt + CNT_W'(1);
`ifdef RESULT_TRANSPOSE_EN
        if (r_row == RW'(M - 1)) begin
          r_row <= '0;
          if (r_col == CW'(P - 1)) begin
            r_col       <= '0;
            r_next_addr <= '0;
          end else begin
            r_col       <= r_col + CW'(1);
            r_next_addr <= ADDR_WIDTH'(r_col) + ADDR_WIDTH'(1);
          end
        end else begin
          r_row       <= r_row + RW'(1);
          r_next_addr <= r_next_addr + ADDR_WIDTH'(P);
        end
`else
        r_next_addr <= (r_next_addr == ADDR_WIDTH'(N - 1)) ? '0 : r_next_addr + ADDR_WIDTH'(1);
`endif
      end

      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state <= READ;
            r_busy  <= 1'b1;
          end
        end
        READ: begin
          if (r_issue_cnt == CNT_W'(N)) begin
            r_state     <= DRAIN;
            r_issue_cnt <= '0;
          end
        end
        DRAIN: begin
          if (w_pop && (r_beat_cnt == LAST)) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_result_reader.sv
// Self-checking bench for matrix_result_reader (M=P=2); honours RESULT_TRANSPOSE_EN.
module tb_matrix_result_reader;
  localparam int unsigned ACC_WIDTH  = 32;
  localparam int unsigned M          = 2;
  localparam int unsigned P          = 2;
  localparam int unsigned N          = M * P;
  localparam int unsigned ADDR_WIDTH = 2;
  localparam int unsigned NV         = 6;

  typedef logic [N-1:0][ACC_WIDTH-1:0] mat_t;
  typedef struct packed {
    logic [ACC_WIDTH-1:0] data;
    logic                 last;
  } beat_t;
  typedef struct {
    mat_t        c;
    logic [15:0] ready;
    int          restart;
    mat_t        exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matrix_result_reader_if #(.ACC_WIDTH(ACC_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  matrix_result_reader #(.ACC_WIDTH(ACC_WIDTH), .M(M), .P(P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [ACC_WIDTH-1:0] cmem [N];
  always @(posedge clk)
    if (bus.bram_en) bus.bram_rdata <= cmem[bus.bram_addr];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic mat_t mk(input int a, input int b, input int c, input int d);
    mat_t m;
    m[0] = ACC_WIDTH'(a); m[1] = ACC_WIDTH'(b); m[2] = ACC_WIDTH'(c); m[3] = ACC_WIDTH'(d);
    return m;
  endfunction

  // Stream order: row-major of C, or row-major of C^T when transposed.
  function automatic mat_t reorder(input mat_t c);
    mat_t o;
    for (int i = 0; i < N; i++) begin
`ifdef RESULT_TRANSPOSE_EN
      o[i] = c[(i % M) * P + (i / M)];
`else
      o[i] = c[i];
`endif
    end
    return o;
  endfunction

  beat_t sb[$];
  int    en_total   = 0;
  int    acc_total  = 0;
  int    beats_seen = 0;
  logic  prev_stall = 1'b0;
  beat_t prev_beat;

  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      sb.delete();
      en_total   = 0;
      acc_total  = 0;
      prev_stall = 1'b0;
    end else begin
      if (bus.bram_en)
        check("issue_with_two_held", 64'((en_total - acc_total) < 2), 64'd1);
      if (prev_stall) begin
        check("stall_valid", 64'(bus.m_valid), 64'd1);
        check("stall_hold", 64'({bus.m_data, bus.m_last}), 64'(prev_beat));
      end
      if (bus.m_valid && bus.m_ready) begin
        if (sb.size() == 0) begin
          check("beat_expected", 64'(sb.size()), 64'd1);
        end else begin
          e = sb.pop_front();
          check("beat_data", 64'(bus.m_data), 64'(e.data));
          check("beat_last", 64'(bus.m_last), 64'(e.last));
        end
        beats_seen++;
        acc_total++;
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_beat  = {bus.m_data, bus.m_last};
      if (bus.bram_en) en_total++;
    end
  end

  task automatic load_and_expect(input mat_t c);
    mat_t x;
    x = reorder(c);
    for (int i = 0; i < N; i++) begin
      cmem[i] = c[i];
      sb.push_back({x[i], (i == N - 1)});
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int dn;
    dn = 0;
    for (int j = 0; j < 60; j++) begin
      @(negedge clk);
      if (bus.done) dn++;
      if (dn > 0 && !bus.done) break;
    end
    check({name, "_done_once"}, 64'(dn), 64'd1);
    check({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_busy"}, 64'(bus.busy), 64'd0);
    check({name, "_done"}, 64'(bus.done), 64'd0);
    check({name, "_bram_en"}, 64'(bus.bram_en), 64'd0);
    check({name, "_bram_addr"}, 64'(bus.bram_addr), 64'd0);
    check({name, "_m_valid"}, 64'(bus.m_valid), 64'd0);
    check({name, "_m_last"}, 64'(bus.m_last), 64'd0);
    check({name, "_m_data"}, 64'(bus.m_data), 64'd0);
  endtask

  vec_t vecs[NV];
  mat_t basic;

  initial begin
    basic = mk(19, 22, 43, 50);
    vecs[0] = '{c: basic, ready: 16'hFFFF, restart: -1, exp: '0};
    vecs[1] = '{c: basic, ready: 16'h9999, restart: -1, exp: '0};
    vecs[2] = '{c: mk(1, 2, 3, 4), ready: 16'hAAAA, restart: -1, exp: '0};
    vecs[3] = '{c: mk(-1, 0, 32'h8000_0000, 1), ready: 16'h3333, restart: -1, exp: '0};
    vecs[4] = '{c: basic, ready: 16'hFFFF, restart: 2, exp: '0};
    vecs[5] = '{c: mk(7, 8, 9, 10), ready: 16'hFFFF, restart: 5, exp: '0};
    for (int v = 0; v < NV; v++) vecs[v].exp = reorder(vecs[v].c);

    rst = 1'b1; bus.start = 1'b1; bus.m_ready = 1'b0;
    for (int i = 0; i < N; i++) cmem[i] = basic[i];
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");
    @(negedge clk);
    check("start_in_reset_ignored", 64'(bus.bram_en), 64'd0);

    // Latency and throughput with the sink always ready.
    bus.m_ready = 1'b1;
    load_and_expect(basic);
    pulse_start();
    @(negedge clk);
    check("lat_k1_bram_en", 64'(bus.bram_en), 64'd1);
    check("lat_k1_m_valid", 64'(bus.m_valid), 64'd0);
    check("lat_k1_busy", 64'(bus.busy), 64'd1);
    @(negedge clk);
    check("lat_k2_m_valid", 64'(bus.m_valid), 64'd1);
    check("lat_k2_m_data", 64'(bus.m_data), 64'd19);
    @(negedge clk);
    check("lat_k3_m_valid", 64'(bus.m_valid), 64'd1);
    @(negedge clk);
    check("lat_k4_m_valid", 64'(bus.m_valid), 64'd1);
    @(negedge clk);
    check("lat_k5_m_last", 64'(bus.m_last), 64'd1);
    check("lat_k5_m_data", 64'(bus.m_data), 64'd50);
    @(negedge clk);
    check("lat_k6_done", 64'(bus.done), 64'd1);
    check("lat_k6_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    check("lat_k7_done", 64'(bus.done), 64'd0);
    check("lat_sb_empty", 64'(sb.size()), 64'd0);

    for (int v = 0; v < NV; v++) begin
      int dn;
      dn = 0;
      load_and_expect(vecs[v].c);
      pulse_start();
      for (int j = 0; j < 60; j++) begin
        bus.m_ready = (j < 16) ? vecs[v].ready[j] : 1'b1;
        bus.start   = (j == vecs[v].restart);
        @(negedge clk);
        if (bus.done) dn++;
        if (dn > 0 && !bus.done) break;
        @(posedge clk); #1;
      end
      @(posedge clk); #1 bus.start = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d_done_once", v), 64'(dn), 64'd1);
      check($sformatf("vec%0d_sb_empty", v), 64'(sb.size()), 64'd0);
      check($sformatf("vec%0d_no_rerun", v), 64'({bus.busy, bus.bram_en}), 64'd0);
    end

    // Sink stalled from start: only two reads may be outstanding.
    begin
      int en_cnt;
      en_cnt = 0;
      bus.m_ready = 1'b0;
      load_and_expect(basic);
      pulse_start();
      repeat (10) begin
        @(negedge clk);
        en_cnt += int'(bus.bram_en);
      end
      check("stall_reads", 64'(en_cnt), 64'd2);
      check("stall_m_valid", 64'(bus.m_valid), 64'd1);
      check("stall_m_data", 64'(bus.m_data), 64'd19);
      @(posedge clk); #1 bus.m_ready = 1'b1;
      wait_done("stall");
    end

    // Reset after the second beat aborts; a fresh start gives the full matrix.
    begin
      int base;
      bit hit;
      base = beats_seen;
      hit  = 1'b0;
      bus.m_ready = 1'b1;
      load_and_expect(basic);
      pulse_start();
      for (int j = 0; j < 40; j++) begin
        @(negedge clk); #1;
        if (beats_seen >= base + 2) begin hit = 1'b1; break; end
      end
      check("abort_two_beats", 64'(hit), 64'd1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check_idle_outputs("abort");
      load_and_expect(basic);
      pulse_start();
      wait_done("after_abort");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL global_timeout: simulation did not complete, got running expected finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end
endmodule
